// File: rtl/mux_2to1_pkg.sv
// Shared sizing defaults and counter saturation helper for the 2:1 selector.
// No clocked logic here.
package mux_2to1_pkg;

    localparam int DEFAULT_WIDTH = 1;
    localparam int DEFAULT_CNT_W = 16;

    // All-ones value of a cnt_w-bit counter; shift-then-subtract also yields all ones at 64 bits.
    function automatic longint unsigned cnt_sat(input int cnt_w);
        return (64'd1 << cnt_w) - 64'd1;
    endfunction

endpackage

// File: rtl/mux_2to1_core.sv
// Combinational 2:1 selector, F = S ? B : A; zero latency.
// No flow control: the output follows the inputs continuously.
module mux_2to1_core #(
    parameter int WIDTH = mux_2to1_pkg::DEFAULT_WIDTH
) (
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             S,
    output logic [WIDTH-1:0] F
);

    assign F = S ? B : A;

endmodule

// File: rtl/mux_2to1.sv
// 2:1 selector with combinational F plus registered F_q/S_q and a saturating S-toggle counter.
// F is zero-latency, registered outputs lag by one edge; no backpressure, accepts every cycle.
module mux_2to1
    import mux_2to1_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int CNT_W = DEFAULT_CNT_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             S,
    output logic [WIDTH-1:0] F,
    output logic [WIDTH-1:0] F_q,
    output logic             S_q,
    output logic [CNT_W-1:0] toggle_cnt
);

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(cnt_sat(CNT_W));

    logic [WIDTH-1:0] f_q, f_d;
    logic             s_q, s_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    mux_2to1_core #(
        .WIDTH (WIDTH)
    ) u_core (
        .A (A),
        .B (B),
        .S (S),
        .F (F)
    );

    // A toggle is a difference between the current S and the last sampled S.
    always_comb begin
        f_d   = F;
        s_d   = S;
        cnt_d = cnt_q;
        if ((S != s_q) && (cnt_q != CNT_MAX)) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            f_q   <= '0;
            s_q   <= 1'b0;
            cnt_q <= '0;
        end else begin
            f_q   <= f_d;
            s_q   <= s_d;
            cnt_q <= cnt_d;
        end
    end

    assign F_q        = f_q;
    assign S_q        = s_q;
    assign toggle_cnt = cnt_q;

endmodule

// File: tb/tb_mux_2to1.sv
// Directed bench for mux_2to1: truth table, 8-bit select, reset, toggle counting, saturation.
module tb_mux_2to1;

    typedef struct {
        logic a;
        logic b;
        logic s;
        logic f;
    } tt_vec_t;

    typedef struct {
        logic       s;
        logic [1:0] cnt;
    } sat_vec_t;

    logic clk;
    logic clk_en;

    logic        rst1, A1, B1, S1;
    logic        F1, Fq1, Sq1;
    logic [15:0] cnt1;

    logic        rst8, S8;
    logic [7:0]  A8, B8, F8, Fq8;
    logic        Sq8;
    logic [15:0] cnt8;

    logic        rst2, A2, B2, S2;
    logic        F2, Fq2, Sq2;
    logic [1:0]  cnt2;

    int checks;
    int errors;

    mux_2to1 #(.WIDTH(1), .CNT_W(16)) dut1 (
        .clk(clk), .rst(rst1), .A(A1), .B(B1), .S(S1),
        .F(F1), .F_q(Fq1), .S_q(Sq1), .toggle_cnt(cnt1)
    );

    mux_2to1 #(.WIDTH(8), .CNT_W(16)) dut8 (
        .clk(clk), .rst(rst8), .A(A8), .B(B8), .S(S8),
        .F(F8), .F_q(Fq8), .S_q(Sq8), .toggle_cnt(cnt8)
    );

    mux_2to1 #(.WIDTH(1), .CNT_W(2)) dut2 (
        .clk(clk), .rst(rst2), .A(A2), .B(B2), .S(S2),
        .F(F2), .F_q(Fq2), .S_q(Sq2), .toggle_cnt(cnt2)
    );

    initial clk = 1'b0;
    always begin
        #5;
        if (clk_en) clk = ~clk;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        tt_vec_t  tt[8];
        sat_vec_t sv[6];
        int       gaps[4];
        logic [15:0] tog_exp[5];
        logic        tog_s[5];

        tt[0] = '{1'b0, 1'b0, 1'b0, 1'b0};
        tt[1] = '{1'b0, 1'b0, 1'b1, 1'b0};
        tt[2] = '{1'b0, 1'b1, 1'b0, 1'b0};
        tt[3] = '{1'b0, 1'b1, 1'b1, 1'b1};
        tt[4] = '{1'b1, 1'b0, 1'b0, 1'b1};
        tt[5] = '{1'b1, 1'b0, 1'b1, 1'b0};
        tt[6] = '{1'b1, 1'b1, 1'b0, 1'b1};
        tt[7] = '{1'b1, 1'b1, 1'b1, 1'b1};
        gaps  = '{7, 2, 7, 3};

        tog_s   = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
        tog_exp = '{16'd1, 16'd2, 16'd3, 16'd3, 16'd4};

        sv[0] = '{1'b1, 2'd1};
        sv[1] = '{1'b0, 2'd2};
        sv[2] = '{1'b1, 2'd3};
        sv[3] = '{1'b0, 2'd3};
        sv[4] = '{1'b1, 2'd3};
        sv[5] = '{1'b0, 2'd3};

        checks = 0;
        errors = 0;
        clk_en = 1'b0;
        rst1 = 1'b0; A1 = 1'b0; B1 = 1'b0; S1 = 1'b0;
        rst8 = 1'b0; A8 = 8'h00; B8 = 8'h00; S8 = 1'b0;
        rst2 = 1'b0; A2 = 1'b0; B2 = 1'b0; S2 = 1'b0;

        // Truth table with the clock held idle.
        for (int i = 0; i < 8; i++) begin
            A1 = tt[i].a;
            B1 = tt[i].b;
            S1 = tt[i].s;
            #(gaps[i % 4]);
            check($sformatf("tt_F[%0d]", i), {31'd0, F1}, {31'd0, tt[i].f});
        end

        // Reset held for two edges; F keeps tracking A.
        A1 = 1'b1; B1 = 1'b0; S1 = 1'b0;
        rst1 = 1'b1; rst8 = 1'b1; rst2 = 1'b1;
        clk_en = 1'b1;
        #1;
        check("rst_F_pre", {31'd0, F1}, 32'd1);
        for (int i = 0; i < 2; i++) begin
            tick();
            check($sformatf("rst_Fq[%0d]", i), {31'd0, Fq1}, 32'd0);
            check($sformatf("rst_Sq[%0d]", i), {31'd0, Sq1}, 32'd0);
            check($sformatf("rst_cnt[%0d]", i), {16'd0, cnt1}, 32'd0);
            check($sformatf("rst_F[%0d]", i), {31'd0, F1}, 32'd1);
        end
        rst1 = 1'b0; rst8 = 1'b0; rst2 = 1'b0;

        // Toggle count: S=1,0,1,1,0. With A=1,B=0 the registered F is ~S.
        for (int i = 0; i < 5; i++) begin
            S1 = tog_s[i];
            tick();
            check($sformatf("tog_cnt[%0d]", i), {16'd0, cnt1}, {16'd0, tog_exp[i]});
            check($sformatf("tog_Sq[%0d]", i), {31'd0, Sq1}, {31'd0, tog_s[i]});
            check($sformatf("tog_Fq[%0d]", i), {31'd0, Fq1}, {31'd0, ~tog_s[i]});
        end

        // Mid-run reset: clear, count back up to 3, then reset while S changes.
        rst1 = 1'b1; S1 = 1'b0;
        tick();
        rst1 = 1'b0;
        S1 = 1'b1; tick();
        S1 = 1'b0; tick();
        S1 = 1'b1; tick();
        check("mid_cnt_pre", {16'd0, cnt1}, 32'd3);
        rst1 = 1'b1; S1 = 1'b0;
        tick();
        check("mid_cnt_rst", {16'd0, cnt1}, 32'd0);
        check("mid_Fq_rst", {31'd0, Fq1}, 32'd0);
        check("mid_Sq_rst", {31'd0, Sq1}, 32'd0);
        rst1 = 1'b0; S1 = 1'b1;
        tick();
        check("mid_cnt_resume", {16'd0, cnt1}, 32'd1);
        check("mid_Sq_resume", {31'd0, Sq1}, 32'd1);

        // 8-bit select.
        A8 = 8'hA5; B8 = 8'h3C; S8 = 1'b0;
        #1;
        check("w8_F_s0", {24'd0, F8}, 32'hA5);
        tick();
        check("w8_Fq_s0", {24'd0, Fq8}, 32'hA5);
        S8 = 1'b1;
        #1;
        check("w8_F_s1", {24'd0, F8}, 32'h3C);
        check("w8_Fq_hold", {24'd0, Fq8}, 32'hA5);
        tick();
        check("w8_Fq_s1", {24'd0, Fq8}, 32'h3C);

        // Saturation with a 2-bit counter.
        check("sat_cnt_start", {30'd0, cnt2}, 32'd0);
        for (int i = 0; i < 6; i++) begin
            S2 = sv[i].s;
            tick();
            check($sformatf("sat_cnt[%0d]", i), {30'd0, cnt2}, {30'd0, sv[i].cnt});
        end

        // A pulse on S between edges that reverts is not counted.
        S2 = 1'b1;
        #2;
        S2 = 1'b0;
        tick();
        check("glitch_Sq", {31'd0, Sq2}, 32'd0);
        rst1 = 1'b0; S1 = 1'b0;
        #2;
        S1 = 1'b1;
        #2;
        S1 = 1'b1;
        tick();
        check("glitch_cnt1_steady", {16'd0, cnt1}, 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
